// File: rtl/reg_scoreboard_pkg.sv
// Shared types and defaults for the register-file hazard scoreboard.
package reg_scoreboard_pkg;

    localparam int SB_NREGS = 32;
    localparam int SB_CNT_W = 2;

    typedef logic [4:0]          reg_idx_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register pending-write counter: up/down, clamped at 0 and max,
// synchronous clear, and an error pulse on a release at zero.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    assign zero = (cnt == '0);
    assign err  = dec & zero;

    // inc together with dec cancels out; neither end of the range wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          cnt <= '0;
        else if (clr)                        cnt <= '0;
        else if (inc && !dec && cnt != MAX)  cnt <= cnt + 1'b1;
        else if (dec && !inc && !zero)       cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard: pending-write count per register, RAW stall.
// Optional macro SCOREBOARD_BYPASS_EN: a source is free in the cycle its last write is released.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREGS = SB_NREGS,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic       clk,
    input  logic       resetn_i,
    input  logic [4:0] ID_SB_rs1_i,
    input  logic [4:0] ID_SB_rs2_i,
    input  logic [4:0] ID_SB_rd_i,
    input  logic       ID_SB_reserve_i,
    output logic       SB_ID_stall_o,
    input  logic [4:0] WB_SB_rd_i,
    input  logic       WB_SB_access_i,
    input  logic       flush_i,
    output logic       SB_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREGS-1:0] busy_v;
    logic [NREGS-1:0] full_v;
    logic [NREGS-1:0] err_v;
    logic             err_q;

    genvar i;
    generate
        for (i = 0; i < NREGS; i++) begin : g_reg
            if (i == 0) begin : g_x0
                assign busy_v[i] = 1'b0;
                assign full_v[i] = 1'b0;
                assign err_v[i]  = 1'b0;
            end else begin : g_cnt
                localparam logic [4:0] IDX = 5'(i);
                logic             inc, dec, rel, zero;
                logic [CNT_W-1:0] cnt;

                assign rel = ~WB_SB_access_i & (WB_SB_rd_i == IDX);
                assign inc = ID_SB_reserve_i & ~SB_ID_stall_o & ~flush_i & (ID_SB_rd_i == IDX);
                assign dec = rel & ~flush_i;

                sb_counter #(.CNT_W(CNT_W)) u_cnt (
                    .clk   (clk),
                    .rst_n (resetn_i),
                    .inc   (inc),
                    .dec   (dec),
                    .clr   (flush_i),
                    .cnt   (cnt),
                    .zero  (zero),
                    .err   (err_v[i])
                );

                assign full_v[i] = (cnt == CNT_MAX);
`ifdef SCOREBOARD_BYPASS_EN
                // write-through register file lets decode read the value being written
                assign busy_v[i] = ~zero & ~(rel & (cnt == CNT_ONE));
`else
                assign busy_v[i] = ~zero;
`endif
            end
        end
    endgenerate

    // full check ignores a same-cycle release of rd on purpose
    assign SB_ID_stall_o = busy_v[ID_SB_rs1_i] | busy_v[ID_SB_rs2_i]
                         | (ID_SB_reserve_i & full_v[ID_SB_rd_i]);

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) err_q <= 1'b0;
        else           err_q <= err_q | (|err_v);
    end

    assign SB_err_o = err_q;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file hazard scoreboard for the in-order pipeline. It tracks, per architectural register, how many in-flight instructions still owe a write-back. Decode reserves the destination register at issue, and write-back releases it when it drives the register-file write port. Decode is stalled while either source operand has a pending write.

## Interface
Parameters:
- NREGS, 32, number of architectural registers (index width = $clog2(NREGS))
- CNT_W, 2, width of each pending-write counter (max outstanding writes per register = 2^CNT_W-1)

Ports:
- clk  input  1  clock, all state on rising edge
- resetn_i  input  1  reset, asynchronous, active-low
- ID_SB_rs1_i  input  5  source register 1 of the instruction in decode
- ID_SB_rs2_i  input  5  source register 2 of the instruction in decode
- ID_SB_rd_i  input  5  destination register of the instruction in decode
- ID_SB_reserve_i  input  1  decode issues an instruction that writes ID_SB_rd_i
- SB_ID_stall_o  output  1  decode must not issue (RAW hazard or counter full)
- WB_SB_rd_i  input  5  register being written by write-back
- WB_SB_access_i  input  1  active-low register-file write strobe from write-back (0 = write this cycle)
- flush_i  input  1  synchronous clear of all pending counts (pipeline flush)
- SB_err_o  output  1  sticky error: release of a register with zero pending count

## Operation
- One counter per register 1..NREGS-1. Register 0 is never tracked. Reserve and release of rd=0 are ignored, and rs=0 is never busy.
- Reserve: when ID_SB_reserve_i=1 and SB_ID_stall_o=0, cnt[rd] increments. A reserve while stalled is ignored; decode holds the instruction.
- Release: when WB_SB_access_i=0, cnt[WB_SB_rd_i] decrements.
- Simultaneous reserve and release of the same rd: the counter is unchanged.
- Release of a register with cnt=0: the counter stays 0 and SB_err_o is set. SB_err_o clears only on reset.
- busy(r) = cnt[r]!=0. SB_ID_stall_o = busy(rs1) | busy(rs2) | (ID_SB_reserve_i & cnt[rd]==max).
- The full condition does not consider a same-cycle release of rd. Stalling is conservative.
- flush_i=1: all counters go to 0 next cycle, and the same-cycle reserve and release are ignored. flush_i does not clear SB_err_o.
- Counters never wrap. Increment at max is impossible because it stalls, and decrement at 0 is the error case above.

## Timing
- Reset (async assert): all counters = 0, SB_err_o = 0, SB_ID_stall_o = 0 (combinational from zero counters).
- SB_ID_stall_o is combinational from the registered counters and the ID_SB_* inputs, with no registered latency.
- Reserve and release update the counters at the next rising edge. A register reserved in cycle N reads busy from cycle N+1.
- Without bypass, a register released in cycle N reads not-busy from cycle N+1.
- Deassertion of resetn_i is synchronised by the top level. The block requires no idle cycle after reset.

## Configuration
- SCOREBOARD_BYPASS_EN defined:
  - A source register reads not-busy in the same cycle its last pending write is released (cnt==1 and WB_SB_access_i=0 with matching rd).
  - The register file is write-through, so decode reads the value being written.
  - This saves one stall cycle per dependency.
- Undefined: busy is purely the registered counter, and stall lasts until the cycle after release.

## Structure
- The shared package holds:
  - NREGS and CNT_W defaults
  - typedef reg_idx_t (logic [4:0])
  - typedef sb_cnt_t (logic [CNT_W-1:0])
  - constant SB_CNT_MAX
- Sub-module sb_counter: one saturating up/down counter with inc, dec, clr, an err pulse and a zero flag. It is instantiated NREGS-1 times by a generate loop. The top level does the rd decoding, the stall reduction and the sticky error.

## Test plan
- Reset mid-operation: with cnt[5]=2, assert resetn_i=0 asynchronously. All counters are 0, SB_ID_stall_o=0 and SB_err_o=0 immediately, before the next edge.
- Reserve then read:
  - Cycle 0: reserve rd=5.
  - Cycle 1: rs1=5 gives SB_ID_stall_o=1.
  - Cycle 3: WB_SB_access_i=0 with rd=5.
  - Stall drops in cycle 4 without bypass, and in cycle 3 with SCOREBOARD_BYPASS_EN.
- Saturation:
  - Reserve rd=7 three times (CNT_W=2).
  - A fourth reserve of rd=7 with rs=0 raises SB_ID_stall_o and cnt[7] stays 3.
  - After one release of rd=7 the reserve is accepted.
- Same-cycle reserve and release: with cnt[9]=1, reserve rd=9 and release rd=9 in the same cycle. cnt[9] stays 1, and rs2=9 reads busy next cycle.
- x0 and error:
  - Reserve rd=0: no state change and no stall with rs1=0.
  - Release rd=12 with cnt[12]=0: SB_err_o=1 from next cycle, persisting through a flush_i pulse.
- Flush: with cnt[3]=2 and cnt[4]=1, pulse flush_i together with a reserve of rd=6. All counters are 0 next cycle, including cnt[6], and SB_ID_stall_o=0 for any rs.
